dyt_rf_wb_arbiter: RTL
======================

Name: dyt_rf_wb_arbiter

Overview:
Write-back controller for the 32x32 flip-flop register file, which has a single write port. Shares that port among NUM_REQ producers (ALU, load unit, CSR unit) using round-robin arbitration with a valid/ready handshake. Drives the register-file write port from a registered stage. Keeps a pending-write scoreboard so decode can stall on read-after-write hazards against the two register-file read ports.

Parameters:
NUM_REQ, 3, number of write-back requesters (2..8)
ADDR_W, 5, register select width (32 registers)
DATA_W, 32, register data width

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a write pending
req_sel  in  NUM_REQ*ADDR_W  destination register of requester i, packed with i=0 in the LSBs
req_data  in  NUM_REQ*DATA_W  write data of requester i, packed
req_ready  out  NUM_REQ  grant; transfer occurs when req_valid[i] & req_ready[i]
rf_wen  out  1  register-file write enable, registered
rf_w_sel  out  ADDR_W  register-file write select, registered
rf_w_data  out  DATA_W  register-file write data, registered
iss_valid  in  1  decode is issuing an instruction that writes iss_rd
iss_rd  in  ADDR_W  destination of the issuing instruction
flush  in  1  pipeline flush; clears the scoreboard
rd_sel_0  in  ADDR_W  mirror of register-file read select 0
rd_sel_1  in  ADDR_W  mirror of register-file read select 1
stall_0  out  1  rd_sel_0 has an outstanding write
stall_1  out  1  rd_sel_1 has an outstanding write
pending  out  32  scoreboard vector, for debug

Behaviour:
- Reset (async, n_rst low): rf_wen=0, rf_w_sel=0, rf_w_data=0, pending=0, rr_ptr=0. Outputs are immediately inactive when n_rst falls; any in-flight write is dropped.
- Arbitration (combinational):
  - Search from index rr_ptr upward, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. At most one ready bit is high per cycle.
  - If no requester is valid, req_ready=0.
  - req_ready never depends on rf state. The port accepts one write every cycle; there is no backpressure beyond arbitration.
- rr_ptr update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ on the next edge. With no grant, rr_ptr holds.
- Write stage, latency 1:
  - A grant at cycle t loads sel/data into the output register.
  - rf_wen=1 during cycle t+1 only, and the register file commits at the end of t+1.
  - With no grant at t, rf_wen=0 at t+1 and sel/data hold their previous values.
- x0 handling: a grant whose sel==0 is consumed (ready=1) but produces rf_wen=0.
- Scoreboard, 32 bits, bit 0 always 0:
  - Set: iss_valid & iss_rd!=0 sets pending[iss_rd] at the edge.
  - Clear: rf_wen=1 clears pending[rf_w_sel] at the same edge the register file commits.
  - Set and clear of the same index in the same cycle: set wins, because a new producer has been issued.
  - flush=1: pending <= 0, except that an iss_valid in the same cycle is ignored. The write stage and rr_ptr are unaffected; an in-flight write still commits.
- Stalls: stall_k = pending[rd_sel_k], purely combinational. Index 0 never stalls.
- Issue to an already-pending register: the bit stays set. In-order producers are required, so the first write-back clears it; the decoder issues a second write to the same rd only after the stall clears.

Optional Feature:
Macro DYT_RF_WB_BYPASS_EN.
- Defined:
  - Adds ports byp_hit_0, byp_hit_1 (out, 1) and byp_data_0, byp_data_1 (out, DATA_W).
  - byp_hit_k = rf_wen & rf_w_sel==rd_sel_k & rd_sel_k!=0, and byp_data_k = rf_w_data.
  - stall_k = pending[rd_sel_k] & ~byp_hit_k, so a consumer issues one cycle earlier using the bypassed data.
- Undefined: these ports are absent and stall_k is as described in Behaviour.

Test Plan:
- Reset mid-write: grant req 0 sel=5 data=0xDEAD, assert n_rst low during the rf_wen cycle -> rf_wen=0 immediately, pending=0, rr_ptr=0 after release.
- Round-robin: all 3 req_valid held high for 6 cycles -> grants 0,1,2,0,1,2; rf_wen=1 on cycles 2..7 with the matching sel/data.
- Latency and scoreboard: iss rd=7 at cycle 0; req 1 sel=7 data=0x1234 granted at cycle 3 -> rf_wen at cycle 4; pending[7] set cycles 1..4, clear from cycle 5; stall_0 with rd_sel_0=7 high through cycle 4.
- x0 write: req 2 sel=0 data=0xFFFFFFFF -> req_ready[2]=1, rf_wen stays 0, pending[0]=0; iss rd=0 -> pending unchanged.
- Set/clear collision: rf_wen commits rd=9 while iss rd=9 in the same cycle -> pending[9]=1 afterwards. Then flush -> pending=0 while an in-flight write still asserts rf_wen.
- Bypass (macro defined): rf_wen=1 sel=9 data=0xABCD, rd_sel_1=9 -> byp_hit_1=1, byp_data_1=0xABCD, stall_1=0. Macro undefined -> stall_1=1.

Source files
------------

// File: rtl/dyt_rf_wb_arbiter_if.sv
// Write-back request bundle: NUM_REQ producers share one register-file write port.
// master = producers (drive valid/sel/data), slave = arbiter (drives ready).
interface dyt_rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_sel;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_sel, output req_data, input req_ready);
  modport slave  (input req_valid, input req_sel, input req_data, output req_ready);
endinterface

// File: rtl/dyt_rf_wb_arbiter.sv
// Round-robin write-back arbiter with registered RF write port (latency 1, no backpressure
// beyond arbitration) and pending-write scoreboard. Optional bypass: DYT_RF_WB_BYPASS_EN.
module dyt_rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      n_rst,
  dyt_rf_wb_arbiter_if.slave        req_if,
  output logic                      rf_wen,
  output logic [ADDR_W-1:0]         rf_w_sel,
  output logic [DATA_W-1:0]         rf_w_data,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_rd,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         rd_sel_0,
  input  logic [ADDR_W-1:0]         rd_sel_1,
`ifdef DYT_RF_WB_BYPASS_EN
  output logic                      byp_hit_0,
  output logic                      byp_hit_1,
  output logic [DATA_W-1:0]         byp_data_0,
  output logic [DATA_W-1:0]         byp_data_1,
`endif
  output logic                      stall_0,
  output logic                      stall_1,
  output logic [(1<<ADDR_W)-1:0]    pending
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              gnt_vld;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W:0]    scan_sum;
  logic [PTR_W-1:0]  scan_idx;
  logic [NUM_REQ-1:0] ready_d;
  logic [ADDR_W-1:0] gnt_sel;
  logic [DATA_W-1:0] gnt_data;

  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NREG-1:0]   pending_q, pending_d;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      scan_idx = scan_sum[PTR_W-1:0];
      if (!gnt_vld && req_if.req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  always_comb begin
    ready_d  = '0;
    gnt_sel  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && gnt_idx == PTR_W'(i)) begin
        ready_d[i] = 1'b1;
        gnt_sel    = req_if.req_sel[i*ADDR_W +: ADDR_W];
        gnt_data   = req_if.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_if.req_ready = ready_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wen_d    = 1'b0;
    sel_d    = sel_q;
    data_d   = data_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      // x0 grants are consumed but never reach the register file.
      wen_d    = (gnt_sel != '0);
      sel_d    = gnt_sel;
      data_d   = gnt_data;
    end
  end

  // A fresh issue beats the commit-clear of the same register; flush beats both.
  always_comb begin
    pending_d = pending_q;
    if (wen_q)
      pending_d[sel_q] = 1'b0;
    if (iss_valid && iss_rd != '0)
      pending_d[iss_rd] = 1'b1;
    if (flush)
      pending_d = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_ptr_q  <= '0;
      wen_q     <= 1'b0;
      sel_q     <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wen_q     <= wen_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  assign rf_wen    = wen_q;
  assign rf_w_sel  = sel_q;
  assign rf_w_data = data_q;
  assign pending   = pending_q;

`ifdef DYT_RF_WB_BYPASS_EN
  assign byp_hit_0  = wen_q && (sel_q == rd_sel_0) && (rd_sel_0 != '0);
  assign byp_hit_1  = wen_q && (sel_q == rd_sel_1) && (rd_sel_1 != '0);
  assign byp_data_0 = data_q;
  assign byp_data_1 = data_q;
  assign stall_0    = pending_q[rd_sel_0] & ~byp_hit_0;
  assign stall_1    = pending_q[rd_sel_1] & ~byp_hit_1;
`else
  assign stall_0    = pending_q[rd_sel_0];
  assign stall_1    = pending_q[rd_sel_1];
`endif

endmodule
